hdc_seq_ctrl: RTL and testbench
===============================

# hdc_seq_ctrl

Sequencing controller for the HDC encode/associative-memory datapath. It accepts train/predict commands and meters a feature stream into the spatial encoder, one `smp_en` per accepted beat. It waits for the temporal encoder's set completion. For train it then issues the AM write; for predict it serially scans per-class similarity scores and returns the arg-max class over a valid/ready result handshake.

## Interface

Clock and reset: one clock; reset is synchronous and active-high.

Parameters:
- `FEAT_NUM`, 16: feature beats per sample.
- `SET_NUM`, 4: samples per set.
- `CLS_NUM`, 10: number of classes, minimum 2.
- `CLS_DW`, 4: class index width, at least clog2(CLS_NUM).
- `SIM_W`, 10: similarity score width, unsigned.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: controller idle, command accepted when both valid and ready are high.
- `cmd_op` in 1: 0 = train, 1 = predict.
- `cmd_label` in CLS_DW: class for train; ignored for predict.
- `feat_valid` in 1: feature beat available on the upstream im_value/im_pos bus.
- `feat_ready` out 1: controller consuming features.
- `smp_en` out 1: encoder enable, equal to feat_valid & feat_ready.
- `set_done` in 1: one-cycle pulse from the temporal encoder.
- `am_we` out 1: AM write strobe, one cycle.
- `am_waddr` out CLS_DW: AM write row.
- `sim_idx` out CLS_DW: class whose score is presented on sim_val.
- `sim_val` in SIM_W: score of class sim_idx, valid in the same cycle.
- `res_valid` out 1: prediction result held.
- `res_ready` in 1: result consumer ready.
- `res_class` out CLS_DW: predicted class.
- `res_score` out SIM_W: winning score.
- `busy` out 1: state != IDLE.
- `err` out 1: sticky error flag; cleared only by rst.

## Operation

States and transitions:
- IDLE: cmd_ready=1. On accept, latch op and label, then go to FEED.
  - If op = train and label >= CLS_NUM, set err and go to FEED anyway. The write is suppressed later, in WAIT.
- FEED: feat_ready=1.
  - Each accepted beat advances feat_cnt over 0..FEAT_NUM-1.
  - On feat_cnt wrap, smp_cnt advances over 0..SET_NUM-1.
  - The beat with feat_cnt=FEAT_NUM-1 and smp_cnt=SET_NUM-1 goes to WAIT; both counters return to 0.
  - A set_done pulse seen in FEED sets err and is otherwise ignored.
- WAIT: feat_ready=0. On set_done:
  - train, label valid: go to WRITE.
  - train, label invalid: go to IDLE.
  - predict: go to SCAN.
  - There is no timeout.
- WRITE: am_we=1 and am_waddr=latched label for exactly one cycle, then go to IDLE.
- SCAN: sim_idx = scan_cnt, running 0..CLS_NUM-1, one class per cycle.
  - At scan_cnt=0, best_val and best_idx load unconditionally.
  - Afterwards they update only when sim_val > best_val (strict), so on a tie the lowest index wins.
  - After index CLS_NUM-1, go to DONE.
- DONE: res_valid=1, and res_class/res_score hold stable. When res_valid & res_ready, go to IDLE.

Output rules:
- Reset value of every output is 0, except cmd_ready=1 (IDLE). All counters, best registers and err clear.
- Reset mid-operation aborts with no AM write and no result.
- Registered outputs: cmd_ready, feat_ready, am_we, am_waddr, sim_idx, res_*, busy, err. smp_en is combinational from feat_valid.
- sim_idx = 0 and am_waddr = 0 outside SCAN and WRITE respectively.
- res_class and res_score keep their last value after the handshake; res_valid falls.

## Timing

- Command accepted at cycle t; FEED is active from t+1.
- With feat_valid held high, the last beat falls at t+FEAT_NUM·SET_NUM, and WAIT begins the cycle after.
- Bubbles on feat_valid stall the counters only; there is no timeout.
- set_done at cycle s in WAIT:
  - train: am_we at s+1, IDLE (cmd_ready=1) at s+2.
  - predict: SCAN covers s+1..s+CLS_NUM, and res_valid rises at s+CLS_NUM+1.
- Result handshake at cycle r: IDLE at r+1. A new command can be accepted at r+1, with no back-to-back overlap.
- Throughput per command is FEAT_NUM·SET_NUM + encoder latency + 2 (train) or + CLS_NUM + 2 (predict) cycles minimum.

## Test plan

Bench configuration unless stated: FEAT_NUM=4, SET_NUM=2, CLS_NUM=4.

1. Train, label 2, feat_valid continuous, set_done 3 cycles after the last beat:
   - exactly 8 smp_en pulses;
   - single am_we with am_waddr=2 exactly 1 cycle after set_done;
   - err=0.
2. Predict with scores {5,9,9,3}: res_class=1, res_score=9 (tie resolves low); res_valid exactly 5 cycles after set_done.
3. Predict with res_ready held low for 10 cycles: res_valid, res_class and res_score stable throughout; cmd_ready=0 until the cycle after res_ready rises.
4. feat_valid toggling 1,0,1,0 during FEED: smp_en count still 8; transition to WAIT only after the 8th accepted beat.
5. Train with label 7 (>= CLS_NUM): err=1, no am_we, IDLE the cycle after set_done. Extra set_done pulse during a later FEED keeps err=1.
6. rst asserted mid-FEED after 5 beats: next cycle all outputs 0 except cmd_ready=1. A fresh train still requires a full 8 beats.

Source files
------------

// File: rtl/hdc_seq_ctrl.sv
// Sequences HDC train/predict: meters feature beats, waits for set completion, then writes AM row or arg-max scans classes.
// Latency: cmd accept to FEED 1 cycle; set_done to am_we 1 cycle, to res_valid CLS_NUM+1 cycles; control outputs are registered.
// Backpressure: feat_valid bubbles stall the beat counters; res_ready low holds the result; cmd_ready stays low until IDLE.
module hdc_seq_ctrl #(
   parameter int FEAT_NUM = 16,
   parameter int SET_NUM  = 4,
   parameter int CLS_NUM  = 10,
   parameter int CLS_DW   = 4,
   parameter int SIM_W    = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_op,
   input  logic [CLS_DW-1:0] cmd_label,
   input  logic              feat_valid,
   output logic              feat_ready,
   output logic              smp_en,
   input  logic              set_done,
   output logic              am_we,
   output logic [CLS_DW-1:0] am_waddr,
   output logic [CLS_DW-1:0] sim_idx,
   input  logic [SIM_W-1:0]  sim_val,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [CLS_DW-1:0] res_class,
   output logic [SIM_W-1:0]  res_score,
   output logic              busy,
   output logic              err
);

   localparam int FW = (FEAT_NUM > 1) ? $clog2(FEAT_NUM) : 1;
   localparam int SW = (SET_NUM > 1) ? $clog2(SET_NUM) : 1;
   localparam logic [FW-1:0]     FEAT_LAST = FW'(FEAT_NUM - 1);
   localparam logic [SW-1:0]     SMP_LAST  = SW'(SET_NUM - 1);
   localparam logic [CLS_DW-1:0] SCAN_LAST = CLS_DW'(CLS_NUM - 1);
   localparam logic [CLS_DW:0]   CLS_LIM   = (CLS_DW + 1)'(CLS_NUM);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FEED,
      S_WAIT,
      S_WRITE,
      S_SCAN,
      S_DONE
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic                op_q;
   logic [CLS_DW-1:0]   label_q;
   logic                lbl_bad_q;
   logic [FW-1:0]       feat_cnt;
   logic [SW-1:0]       smp_cnt;
   logic [CLS_DW-1:0]   scan_cnt;
   logic [SIM_W-1:0]    best_val;
   logic [CLS_DW-1:0]   best_idx;
   logic                cmd_acc;
   logic                last_beat;
   logic                take;
   logic [SIM_W-1:0]    cand_val;
   logic [CLS_DW-1:0]   cand_idx;

   // Encoder enable is the raw beat handshake so the encoder sees the beat in the same cycle.
   assign smp_en  = feat_valid & feat_ready;
   assign cmd_acc = cmd_valid & cmd_ready;
   // scan_cnt is parked at 0 outside SCAN, so it doubles as the score-select index.
   assign sim_idx = scan_cnt;

   // Next-state decode plus the running arg-max candidate (first cycle loads, later only strictly greater wins).
   always_comb begin
      state_nxt = state;
      last_beat = smp_en && (feat_cnt == FEAT_LAST) && (smp_cnt == SMP_LAST);
      take      = (scan_cnt == '0) || (sim_val > best_val);
      cand_val  = take ? sim_val  : best_val;
      cand_idx  = take ? scan_cnt : best_idx;
      case (state)
         S_IDLE:  if (cmd_acc) state_nxt = S_FEED;
         S_FEED:  if (last_beat) state_nxt = S_WAIT;
         S_WAIT: begin
            if (set_done) begin
               if (op_q)           state_nxt = S_SCAN;
               else if (lbl_bad_q) state_nxt = S_IDLE;
               else                state_nxt = S_WRITE;
            end
         end
         S_WRITE: state_nxt = S_IDLE;
         S_SCAN:  if (scan_cnt == SCAN_LAST) state_nxt = S_DONE;
         S_DONE:  if (res_valid && res_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State, counters, latched command and registered outputs decoded from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         op_q       <= 1'b0;
         label_q    <= '0;
         lbl_bad_q  <= 1'b0;
         feat_cnt   <= '0;
         smp_cnt    <= '0;
         scan_cnt   <= '0;
         best_val   <= '0;
         best_idx   <= '0;
         cmd_ready  <= 1'b1;
         feat_ready <= 1'b0;
         am_we      <= 1'b0;
         am_waddr   <= '0;
         res_valid  <= 1'b0;
         res_class  <= '0;
         res_score  <= '0;
         busy       <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_nxt;
         cmd_ready  <= (state_nxt == S_IDLE);
         feat_ready <= (state_nxt == S_FEED);
         busy       <= (state_nxt != S_IDLE);
         am_we      <= (state_nxt == S_WRITE);
         am_waddr   <= (state_nxt == S_WRITE) ? label_q : '0;
         res_valid  <= (state_nxt == S_DONE);

         if (cmd_acc) begin
            op_q    <= cmd_op;
            label_q <= cmd_label;
            if (!cmd_op && ({1'b0, cmd_label} >= CLS_LIM)) begin
               lbl_bad_q <= 1'b1;
               err       <= 1'b1;
            end else begin
               lbl_bad_q <= 1'b0;
            end
         end

         // A set completion while still feeding means the encoder and controller are out of step.
         if ((state == S_FEED) && set_done) err <= 1'b1;

         if (smp_en) begin
            if (feat_cnt == FEAT_LAST) begin
               feat_cnt <= '0;
               smp_cnt  <= (smp_cnt == SMP_LAST) ? '0 : smp_cnt + 1'b1;
            end else begin
               feat_cnt <= feat_cnt + 1'b1;
            end
         end

         if (state == S_SCAN) begin
            best_val <= cand_val;
            best_idx <= cand_idx;
            if (scan_cnt == SCAN_LAST) begin
               scan_cnt  <= '0;
               res_class <= cand_idx;
               res_score <= cand_val;
            end else begin
               scan_cnt <= scan_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_hdc_seq_ctrl.sv
// Scoreboard bench for hdc_seq_ctrl: directed scenarios followed by randomized commands.
// Expected AM writes and predictions are queued at issue time and popped by a negedge monitor.
// Timing of each phase is checked by the stimulus thread one step after each rising edge.
module tb_hdc_seq_ctrl;

   localparam int FEAT_NUM = 4;
   localparam int SET_NUM  = 2;
   localparam int CLS_NUM  = 4;
   localparam int CLS_DW   = 4;
   localparam int SIM_W    = 10;
   localparam int BEATS    = FEAT_NUM * SET_NUM;

   logic              clk;
   logic              rst;
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_op;
   logic [CLS_DW-1:0] cmd_label;
   logic              feat_valid;
   logic              feat_ready;
   logic              smp_en;
   logic              set_done;
   logic              am_we;
   logic [CLS_DW-1:0] am_waddr;
   logic [CLS_DW-1:0] sim_idx;
   logic [SIM_W-1:0]  sim_val;
   logic              res_valid;
   logic              res_ready;
   logic [CLS_DW-1:0] res_class;
   logic [SIM_W-1:0]  res_score;
   logic              busy;
   logic              err;

   typedef struct {
      bit is_pred;
      int cls;
      int score;
   } exp_t;

   exp_t             exp_q[$];
   exp_t             mon_e;
   logic [SIM_W-1:0] score_tab [16];
   int               n_cmp;
   int               n_err;
   int               smp_seen;
   bit               err_exp;

   hdc_seq_ctrl #(
      .FEAT_NUM (FEAT_NUM),
      .SET_NUM  (SET_NUM),
      .CLS_NUM  (CLS_NUM),
      .CLS_DW   (CLS_DW),
      .SIM_W    (SIM_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_label  (cmd_label),
      .feat_valid (feat_valid),
      .feat_ready (feat_ready),
      .smp_en     (smp_en),
      .set_done   (set_done),
      .am_we      (am_we),
      .am_waddr   (am_waddr),
      .sim_idx    (sim_idx),
      .sim_val    (sim_val),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_class  (res_class),
      .res_score  (res_score),
      .busy       (busy),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // The similarity memory answers combinationally for whichever class the DUT selects.
   assign sim_val = score_tab[sim_idx];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference prediction: highest score, lowest class index among equal maxima.
   task automatic ref_pred(output int cls, output int sc);
      int mx;
      mx = 0;
      for (int i = 0; i < CLS_NUM; i++)
         if (int'(score_tab[i]) > mx) mx = int'(score_tab[i]);
      cls = 0;
      for (int i = CLS_NUM - 1; i >= 0; i--)
         if (int'(score_tab[i]) == mx) cls = i;
      sc = mx;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_cmd_ready"},  cmd_ready,  1);
      check({tag, "_feat_ready"}, feat_ready, 0);
      check({tag, "_smp_en"},     smp_en,     0);
      check({tag, "_am_we"},      am_we,      0);
      check({tag, "_am_waddr"},   am_waddr,   0);
      check({tag, "_sim_idx"},    sim_idx,    0);
      check({tag, "_res_valid"},  res_valid,  0);
      check({tag, "_res_class"},  res_class,  0);
      check({tag, "_res_score"},  res_score,  0);
      check({tag, "_busy"},       busy,       0);
      check({tag, "_err"},        err,        0);
   endtask

   task automatic issue_cmd(input bit op, input int label);
      int n;
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!cmd_ready) check("cmd_ready_timeout", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_label = CLS_DW'(label);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   // pat: 0 continuous, 1 alternating starting high, 2 random bubbles.
   task automatic do_cmd(input bit op, input int label, input int pat, input int gap,
                         input int hold, input bit fd_pulse);
      exp_t e;
      int   beats, it, smp_start, c, s;
      bit   v;
      if (!op && label < CLS_NUM) begin
         e.is_pred = 0; e.cls = label; e.score = 0;
         exp_q.push_back(e);
      end else if (op) begin
         ref_pred(c, s);
         e.is_pred = 1; e.cls = c; e.score = s;
         exp_q.push_back(e);
      end
      if (!op && label >= CLS_NUM) err_exp = 1;
      if (fd_pulse) err_exp = 1;

      issue_cmd(op, label);
      smp_start = smp_seen;
      check("feed_cmd_ready", cmd_ready, 0);
      check("feed_busy", busy, 1);

      beats = 0;
      it    = 0;
      while (beats < BEATS && it < 200) begin
         v = (pat == 0) ? 1'b1 : (pat == 1) ? (it % 2 == 0) : 1'($urandom_range(0, 1));
         feat_valid = v;
         set_done   = (fd_pulse && it == 2);
         @(negedge clk);
         check("feat_ready_in_feed", feat_ready, 1);
         check("smp_en_beat", smp_en, int'(v));
         if (v) beats++;
         it++;
         @(posedge clk); #1;
      end
      set_done = 1'b0;
      if (beats < BEATS) check("feed_timeout", beats, BEATS);

      // WAIT: extra feature offers must not be consumed.
      check("wait_feat_ready", feat_ready, 0);
      check("wait_busy", busy, 1);
      feat_valid = 1'b1;
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         check("wait_smp_en", smp_en, 0);
         @(posedge clk); #1;
      end
      feat_valid = 1'($urandom_range(0, 1));
      set_done   = 1'b1;
      @(posedge clk); #1;
      set_done   = 1'b0;
      feat_valid = 1'b0;
      check("smp_en_total", smp_seen - smp_start, BEATS);

      if (!op && label < CLS_NUM) begin
         check("am_we_at_s1", am_we, 1);
         check("am_waddr_at_s1", am_waddr, label);
         check("cmd_ready_at_s1", cmd_ready, 0);
         @(posedge clk); #1;
         check("am_we_at_s2", am_we, 0);
         check("am_waddr_at_s2", am_waddr, 0);
         check("cmd_ready_at_s2", cmd_ready, 1);
      end else if (!op) begin
         check("bad_am_we", am_we, 0);
         check("bad_cmd_ready_at_s1", cmd_ready, 1);
         check("bad_busy_at_s1", busy, 0);
      end else begin
         for (int k = 0; k < CLS_NUM; k++) begin
            check("scan_sim_idx", sim_idx, k);
            check("scan_res_valid", res_valid, 0);
            if (k < CLS_NUM - 1) begin
               @(posedge clk); #1;
            end
         end
         @(posedge clk); #1;
         check("res_valid_rise", res_valid, 1);
         check("done_sim_idx", sim_idx, 0);
         for (int h = 0; h < hold; h++) begin
            check("hold_cmd_ready", cmd_ready, 0);
            check("hold_res_valid", res_valid, 1);
            @(posedge clk); #1;
         end
         res_ready = 1'b1;
         @(posedge clk); #1;
         res_ready = 1'b0;
         check("post_hs_res_valid", res_valid, 0);
         check("post_hs_cmd_ready", cmd_ready, 1);
         check("post_hs_res_class", res_class, e.cls);
      end
      check("err_sticky", err, int'(err_exp));
   endtask

   // Scoreboard monitor: every AM write and every presented result is checked against the queue head.
   always @(negedge clk) begin
      if (smp_en) smp_seen++;
      if (am_we) begin
         if (exp_q.size() == 0) begin
            check("am_we_unexpected", am_we, 0);
         end else begin
            mon_e = exp_q.pop_front();
            check("wr_kind", int'(mon_e.is_pred), 0);
            check("am_waddr", am_waddr, mon_e.cls);
         end
      end
      if (res_valid) begin
         if (exp_q.size() == 0) begin
            check("res_valid_unexpected", res_valid, 0);
         end else begin
            check("res_kind", int'(exp_q[0].is_pred), 1);
            check("res_class", res_class, exp_q[0].cls);
            check("res_score", res_score, exp_q[0].score);
            if (res_ready) mon_e = exp_q.pop_front();
         end
      end
   end

   initial begin
      n_cmp      = 0;
      n_err      = 0;
      smp_seen   = 0;
      err_exp    = 0;
      rst        = 1'b1;
      cmd_valid  = 1'b0;
      cmd_op     = 1'b0;
      cmd_label  = '0;
      feat_valid = 1'b1;
      set_done   = 1'b0;
      res_ready  = 1'b0;
      for (int i = 0; i < 16; i++) score_tab[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      rst        = 1'b0;
      feat_valid = 1'b0;
      @(posedge clk); #1;

      // Train label 2, continuous features, set_done three cycles after the last beat.
      do_cmd(0, 2, 0, 2, 0, 0);
      check("t1_err", err, 0);

      // Predict with a tie on the maximum: lowest index wins.
      score_tab[0] = 10'd5; score_tab[1] = 10'd9; score_tab[2] = 10'd9; score_tab[3] = 10'd3;
      do_cmd(1, 0, 0, 1, 0, 0);

      // Predict with result held for ten cycles.
      score_tab[0] = 10'd17; score_tab[1] = 10'd400; score_tab[2] = 10'd2; score_tab[3] = 10'd1023;
      do_cmd(1, 0, 0, 0, 10, 0);

      // Bubbled features.
      do_cmd(0, 1, 1, 1, 0, 0);

      // Invalid label, then a stray set_done during a later feed.
      do_cmd(0, 7, 0, 1, 0, 0);
      do_cmd(0, 3, 0, 2, 0, 1);

      // Abort mid-feed after five beats, then a full fresh train.
      issue_cmd(0, 0);
      feat_valid = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      err_exp = 0;
      check_idle_outputs("midrst");
      rst        = 1'b0;
      feat_valid = 1'b0;
      @(posedge clk); #1;
      do_cmd(0, 0, 0, 1, 0, 0);

      // Randomized commands; small score range forces frequent ties.
      for (int n = 0; n < 24; n++) begin
         for (int i = 0; i < CLS_NUM; i++) score_tab[i] = SIM_W'($urandom_range(0, 15));
         if (n % 5 == 4) score_tab[$urandom_range(0, CLS_NUM - 1)] = SIM_W'($urandom_range(1000, 1023));
         do_cmd(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 2),
                $urandom_range(0, 4), $urandom_range(0, 3), 1'b0);
      end

      repeat (3) @(posedge clk);
      #1;
      check("queue_drained", exp_q.size(), 0);
      check("final_err", err, int'(err_exp));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
